// File: rtl/jtcontra_obj_arb_pkg.sv
// -----------------------------------------------------------------------------
// jtcontra_obj_arb_pkg
// Shared definitions for the 007121 object ROM arbiter.
//   arb_state_t   : grant FSM states (IDLE, WAIT)
//   PORT_A/PORT_B : port index constants used for grant and round-robin
//   DEF_*_OFFSET  : default SDRAM word offsets for each object chip region
// -----------------------------------------------------------------------------
package jtcontra_obj_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [31:0] DEF_A_OFFSET = 32'h0000_0000;
    localparam logic [31:0] DEF_B_OFFSET = 32'h0004_0000;

endpackage

// File: rtl/jtcontra_obj_arb_port.sv
// -----------------------------------------------------------------------------
// jtcontra_obj_arb_port
// Per-engine side of the object ROM arbiter. Holds the delivered word, the
// address it belongs to and a valid flag, and reports whether the engine
// still needs a fetch.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_cs, i_addr : engine request and word address
//   i_deliver    : one-cycle strobe, fresh data for this port
//   i_del_addr   : address the delivered data was fetched for
//   i_data       : delivered data
//   o_ok         : data valid for the address currently requested
//   o_pending    : engine wants a fetch (requesting, no valid data held)
//   o_data       : last delivered data, held until the next delivery
// -----------------------------------------------------------------------------
module jtcontra_obj_arb_port
    import jtcontra_obj_arb_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    input  logic          i_deliver,
    input  logic [AW-1:0] i_del_addr,
    input  logic [15:0]   i_data,
    output logic          o_ok,
    output logic          o_pending,
    output logic [15:0]   o_data
);

    logic          r_ok_flag;
    logic [AW-1:0] r_ok_addr;
    logic [15:0]   r_data;
    logic          w_match;

    assign w_match   = (i_addr == r_ok_addr);
    // ok is qualified live by cs/addr so a retarget hides old data at once
    assign o_ok      = r_ok_flag & i_cs & w_match;
    assign o_pending = i_cs & ~r_ok_flag;
    assign o_data    = r_data;

    // Delivery wins over clearing; the flag is only cleared once the
    // engine has been seen dropping cs or moving to another address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok_flag <= 1'b0;
            r_ok_addr <= '0;
            r_data    <= '0;
        end else if (i_deliver) begin
            r_ok_flag <= 1'b1;
            r_ok_addr <= i_del_addr;
            r_data    <= i_data;
        end else if (r_ok_flag && (!i_cs || !w_match)) begin
            r_ok_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/jtcontra_obj_rom_arb.sv
// -----------------------------------------------------------------------------
// jtcontra_obj_rom_arb
// Shares one SDRAM read slot between the two 007121 object engines.
// Requests are granted round-robin, each port's region offset is added,
// requests aborted or retargeted while in flight have their data dropped,
// and a watchdog flags an SDRAM that never acknowledges.
//   clk, rst_n             : clock, asynchronous active-low reset
//   a_cs/a_addr/a_ok/a_data: object chip 0 ROM handshake
//   b_cs/b_addr/b_ok/b_data: object chip 1 ROM handshake
//   sdram_cs/sdram_addr    : SDRAM request (held until ok or timeout)
//   sdram_ok/sdram_data    : single-cycle SDRAM acknowledge and data
//   err                    : sticky watchdog flag
//   busy                   : request outstanding
// -----------------------------------------------------------------------------
module jtcontra_obj_rom_arb
    import jtcontra_obj_arb_pkg::*;
#(
    parameter int          AW       = 18,
    parameter int          SW       = 19,
    parameter logic [SW-1:0] A_OFFSET = SW'(DEF_A_OFFSET),
    parameter logic [SW-1:0] B_OFFSET = SW'(DEF_B_OFFSET),
    parameter int          TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_cs,
    input  logic [AW-1:0] a_addr,
    output logic          a_ok,
    output logic [15:0]   a_data,
    input  logic          b_cs,
    input  logic [AW-1:0] b_addr,
    output logic          b_ok,
    output logic [15:0]   b_data,
    output logic          sdram_cs,
    output logic [SW-1:0] sdram_addr,
    input  logic          sdram_ok,
    input  logic [15:0]   sdram_data,
    output logic          err,
    output logic          busy
);

    // Counter only needs to reach TIMEOUT-1 before the timeout fires
    localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t    r_state;
    logic          r_gnt;
    logic          r_last_gnt;
    logic [AW-1:0] r_req_addr;
    logic          r_stale;
    logic [CW-1:0] r_cnt;
    logic          r_sdram_cs;
    logic [SW-1:0] r_sdram_addr;
    logic          r_busy;
    logic          r_err;

    logic          w_pend_a;
    logic          w_pend_b;
    logic          w_pick;
    logic [AW-1:0] w_pick_addr;
    logic [SW-1:0] w_new_addr;
    logic          w_cur_cs;
    logic [AW-1:0] w_cur_addr;
    logic          w_stale;
    logic          w_deliver;
    logic          w_deliver_a;
    logic          w_deliver_b;
    logic          w_timeout;

    // Round-robin choice: a lone pending port wins, a tie goes to the
    // port that was not served last.
    always_comb begin
        w_pick = PORT_A;
        if (w_pend_a && w_pend_b) begin
            w_pick = ~r_last_gnt;
        end else if (w_pend_b) begin
            w_pick = PORT_B;
        end
        w_pick_addr = (w_pick == PORT_B) ? b_addr : a_addr;
        w_new_addr  = (w_pick == PORT_B) ? SW'(b_addr) + B_OFFSET
                                         : SW'(a_addr) + A_OFFSET;
    end

    // A request turns stale as soon as its engine drops cs or moves away,
    // and stays stale until the SDRAM answers.
    always_comb begin
        w_cur_cs    = (r_gnt == PORT_B) ? b_cs   : a_cs;
        w_cur_addr  = (r_gnt == PORT_B) ? b_addr : a_addr;
        w_stale     = r_stale | ~w_cur_cs | (w_cur_addr != r_req_addr);
        w_deliver   = (r_state == WAIT) & sdram_ok & ~w_stale;
        w_deliver_a = w_deliver & (r_gnt == PORT_A);
        w_deliver_b = w_deliver & (r_gnt == PORT_B);
        w_timeout   = (TIMEOUT != 0) && (r_cnt == LIMIT);
    end

    // Grant FSM. IDLE always follows a deasserted sdram_cs, so every
    // request is separated by at least one low cycle. A late sdram_ok
    // seen in IDLE is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= PORT_A;
            r_last_gnt   <= PORT_B;
            r_req_addr   <= '0;
            r_stale      <= 1'b0;
            r_cnt        <= '0;
            r_sdram_cs   <= 1'b0;
            r_sdram_addr <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pend_a || w_pend_b) begin
                        r_sdram_cs   <= 1'b1;
                        r_sdram_addr <= w_new_addr;
                        r_req_addr   <= w_pick_addr;
                        r_gnt        <= w_pick;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_stale      <= 1'b0;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    r_stale <= w_stale;
                    if (sdram_ok) begin
                        r_sdram_cs <= 1'b0;
                        r_busy     <= 1'b0;
                        r_last_gnt <= r_gnt;
                        r_state    <= IDLE;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_sdram_cs <= 1'b0;
                        r_busy     <= 1'b0;
                        r_last_gnt <= r_gnt;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sdram_cs   = r_sdram_cs;
    assign sdram_addr = r_sdram_addr;
    assign busy       = r_busy;
    assign err        = r_err;

    jtcontra_obj_arb_port #(.AW(AW)) u_port_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cs       (a_cs),
        .i_addr     (a_addr),
        .i_deliver  (w_deliver_a),
        .i_del_addr (r_req_addr),
        .i_data     (sdram_data),
        .o_ok       (a_ok),
        .o_pending  (w_pend_a),
        .o_data     (a_data)
    );

    jtcontra_obj_arb_port #(.AW(AW)) u_port_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cs       (b_cs),
        .i_addr     (b_addr),
        .i_deliver  (w_deliver_b),
        .i_del_addr (r_req_addr),
        .i_data     (sdram_data),
        .o_ok       (b_ok),
        .o_pending  (w_pend_b),
        .o_data     (b_data)
    );

endmodule

// File: tb/tb_jtcontra_obj_rom_arb.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_obj_rom_arb
// Directed bench for the object ROM arbiter: a vector table for single
// requests and round-robin contention, then hand-written sequences for
// abort, retarget, watchdog and reset in flight.
// -----------------------------------------------------------------------------
module tb_jtcontra_obj_rom_arb;

    logic        clk;
    logic        rst_n;
    logic        a_cs;
    logic [17:0] a_addr;
    logic        a_ok;
    logic [15:0] a_data;
    logic        b_cs;
    logic [17:0] b_addr;
    logic        b_ok;
    logic [15:0] b_data;
    logic        sdram_cs;
    logic [18:0] sdram_addr;
    logic        sdram_ok;
    logic [15:0] sdram_data;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        aCs;
        logic [17:0] aAddr;
        logic        bCs;
        logic [17:0] bAddr;
        logic        sOk;
        logic [15:0] sData;
        logic        eCs;
        logic [18:0] eAddr;
        logic        eAOk;
        logic [15:0] eAData;
        logic        eBOk;
        logic [15:0] eBData;
        logic        eBusy;
        logic        eErr;
    } vec_t;

    vec_t vecs[18];

    jtcontra_obj_rom_arb #(
        .AW      (18),
        .SW      (19),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_cs       (a_cs),
        .a_addr     (a_addr),
        .a_ok       (a_ok),
        .a_data     (a_data),
        .b_cs       (b_cs),
        .b_addr     (b_addr),
        .b_ok       (b_ok),
        .b_data     (b_data),
        .sdram_cs   (sdram_cs),
        .sdram_addr (sdram_addr),
        .sdram_ok   (sdram_ok),
        .sdram_data (sdram_data),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eCs,
                            input logic [18:0] eAddr, input logic eAOk,
                            input logic [15:0] eAData, input logic eBOk,
                            input logic [15:0] eBData, input logic eBusy,
                            input logic eErr);
        checkOutput({tag, " sdram_cs"},   32'(sdram_cs),   32'(eCs));
        checkOutput({tag, " sdram_addr"}, 32'(sdram_addr), 32'(eAddr));
        checkOutput({tag, " a_ok"},       32'(a_ok),       32'(eAOk));
        checkOutput({tag, " a_data"},     32'(a_data),     32'(eAData));
        checkOutput({tag, " b_ok"},       32'(b_ok),       32'(eBOk));
        checkOutput({tag, " b_data"},     32'(b_data),     32'(eBData));
        checkOutput({tag, " busy"},       32'(busy),       32'(eBusy));
        checkOutput({tag, " err"},        32'(err),        32'(eErr));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after
    // the following rising edge with the same inputs still applied.
    task automatic applyStimulus(input logic aCs, input logic [17:0] aAddr,
                                 input logic bCs, input logic [17:0] bAddr,
                                 input logic sOk, input logic [15:0] sData);
        @(negedge clk);
        a_cs       = aCs;
        a_addr     = aAddr;
        b_cs       = bCs;
        b_addr     = bAddr;
        sdram_ok   = sOk;
        sdram_data = sData;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n      = 1'b0;
        a_cs       = 1'b0;
        a_addr     = '0;
        b_cs       = 1'b0;
        b_addr     = '0;
        sdram_ok   = 1'b0;
        sdram_data = '0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Single request on A, SDRAM answers two cycles after cs
        vecs[0]  = '{1'b1, 1'b1, 18'h00123, 1'b0, 18'h0, 1'b0, 16'h0,      1'b1, 19'h00123, 1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 18'h00123, 1'b0, 18'h0, 1'b0, 16'h0,      1'b1, 19'h00123, 1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 18'h00123, 1'b0, 18'h0, 1'b0, 16'h0,      1'b1, 19'h00123, 1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 18'h00123, 1'b0, 18'h0, 1'b1, 16'hBEEF,   1'b0, 19'h00123, 1'b1, 16'hBEEF, 1'b0, 16'h0,    1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 18'h00123, 1'b0, 18'h0, 1'b0, 16'h0,      1'b0, 19'h00123, 1'b1, 16'hBEEF, 1'b0, 16'h0,    1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 18'h00123, 1'b0, 18'h0, 1'b0, 16'h0,      1'b0, 19'h00123, 1'b0, 16'hBEEF, 1'b0, 16'h0,    1'b0, 1'b0};
        // Contention from reset: A first, then B with its region offset
        vecs[6]  = '{1'b1, 1'b1, 18'h00050, 1'b1, 18'h00010, 1'b0, 16'h0,    1'b1, 19'h00050, 1'b0, 16'h0,    1'b0, 16'h0,    1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 18'h00050, 1'b1, 18'h00010, 1'b1, 16'h1111, 1'b0, 19'h00050, 1'b1, 16'h1111, 1'b0, 16'h0,    1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 18'h00050, 1'b1, 18'h00010, 1'b0, 16'h0,    1'b1, 19'h40010, 1'b1, 16'h1111, 1'b0, 16'h0,    1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 18'h00050, 1'b1, 18'h00010, 1'b1, 16'h2222, 1'b0, 19'h40010, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 18'h00050, 1'b0, 18'h00010, 1'b0, 16'h0,    1'b0, 19'h40010, 1'b0, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0};
        // A served alone, so the next tie must go to B
        vecs[11] = '{1'b0, 1'b1, 18'h00070, 1'b0, 18'h00010, 1'b0, 16'h0,    1'b1, 19'h00070, 1'b0, 16'h1111, 1'b0, 16'h2222, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 18'h00070, 1'b0, 18'h00010, 1'b1, 16'h3333, 1'b0, 19'h00070, 1'b1, 16'h3333, 1'b0, 16'h2222, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 18'h00070, 1'b0, 18'h00010, 1'b0, 16'h0,    1'b0, 19'h00070, 1'b0, 16'h3333, 1'b0, 16'h2222, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 18'h00080, 1'b1, 18'h00090, 1'b0, 16'h0,    1'b1, 19'h40090, 1'b0, 16'h3333, 1'b0, 16'h2222, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 18'h00080, 1'b1, 18'h00090, 1'b1, 16'h4444, 1'b0, 19'h40090, 1'b0, 16'h3333, 1'b1, 16'h4444, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 18'h00080, 1'b1, 18'h00090, 1'b0, 16'h0,    1'b1, 19'h00080, 1'b0, 16'h3333, 1'b1, 16'h4444, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 18'h00080, 1'b1, 18'h00090, 1'b1, 16'h5555, 1'b0, 19'h00080, 1'b1, 16'h5555, 1'b1, 16'h4444, 1'b0, 1'b0};

        rst_n      = 1'b0;
        a_cs       = 1'b0;
        a_addr     = '0;
        b_cs       = 1'b0;
        b_addr     = '0;
        sdram_ok   = 1'b0;
        sdram_data = '0;
        #12;
        checkAll("reset", 1'b0, 19'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].aCs, vecs[i].aAddr, vecs[i].bCs,
                          vecs[i].bAddr, vecs[i].sOk, vecs[i].sData);
            checkAll($sformatf("vec%0d", i), vecs[i].eCs, vecs[i].eAddr,
                     vecs[i].eAOk, vecs[i].eAData, vecs[i].eBOk,
                     vecs[i].eBData, vecs[i].eBusy, vecs[i].eErr);
        end

        // Abort: B drops cs in WAIT, data is discarded, A goes next
        doReset();
        applyStimulus(1'b0, 18'h0, 1'b1, 18'h00200, 1'b0, 16'h0);
        checkAll("abort grant", 1'b1, 19'h40200, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 18'h00300, 1'b0, 18'h00200, 1'b0, 16'h0);
        checkAll("abort hold", 1'b1, 19'h40200, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 18'h00300, 1'b0, 18'h00200, 1'b1, 16'hDEAD);
        checkAll("abort drop", 1'b0, 19'h40200, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 18'h00300, 1'b0, 18'h00200, 1'b0, 16'h0);
        checkAll("abort next A", 1'b1, 19'h00300, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 18'h00300, 1'b0, 18'h00200, 1'b1, 16'h0A0A);
        checkAll("abort A data", 1'b0, 19'h00300, 1'b1, 16'h0A0A, 1'b0, 16'h0, 1'b0, 1'b0);

        // Retarget: A moves address while in WAIT
        doReset();
        applyStimulus(1'b1, 18'h00100, 1'b0, 18'h0, 1'b0, 16'h0);
        checkAll("retgt grant", 1'b1, 19'h00100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 18'h00104, 1'b0, 18'h0, 1'b0, 16'h0);
        checkAll("retgt move", 1'b1, 19'h00100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 18'h00104, 1'b0, 18'h0, 1'b1, 16'h1234);
        checkAll("retgt drop", 1'b0, 19'h00100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 18'h00104, 1'b0, 18'h0, 1'b0, 16'h0);
        checkAll("retgt regrant", 1'b1, 19'h00104, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 18'h00104, 1'b0, 18'h0, 1'b1, 16'h5678);
        checkAll("retgt data", 1'b0, 19'h00104, 1'b1, 16'h5678, 1'b0, 16'h0, 1'b0, 1'b0);

        // Watchdog: no sdram_ok, timeout after 8 WAIT cycles
        doReset();
        applyStimulus(1'b0, 18'h0, 1'b1, 18'h00005, 1'b0, 16'h0);
        checkAll("wd grant", 1'b1, 19'h40005, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 18'h0, 1'b1, 18'h00005, 1'b0, 16'h0);
        end
        checkAll("wd before", 1'b1, 19'h40005, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 18'h0, 1'b1, 18'h00005, 1'b0, 16'h0);
        checkAll("wd fire", 1'b0, 19'h40005, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 18'h0, 1'b1, 18'h00005, 1'b0, 16'h0);
        checkAll("wd regrant", 1'b1, 19'h40005, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 18'h0, 1'b1, 18'h00005, 1'b1, 16'h7777);
        checkAll("wd served", 1'b0, 19'h40005, 1'b0, 16'h0, 1'b1, 16'h7777, 1'b0, 1'b1);

        // Reset while a request is in flight; late ack must be ignored
        applyStimulus(1'b1, 18'h00010, 1'b0, 18'h00005, 1'b0, 16'h0);
        checkAll("rst grant", 1'b1, 19'h00010, 1'b0, 16'h0, 1'b0, 16'h7777, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        a_cs  = 1'b0;
        #1;
        checkAll("rst async", 1'b0, 19'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 18'h00010, 1'b0, 18'h00005, 1'b1, 16'hFFFF);
        checkAll("rst late ok", 1'b0, 19'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 18'h00010, 1'b0, 18'h00005, 1'b0, 16'h0);
        checkAll("rst settle", 1'b0, 19'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
